// File: rtl/mem_bus_responder.sv
// Single-cycle data-memory responder: byte-addressable RAM plus LED, switch and
// optional timer registers. Define IO_TIMER_EN to include the timer block.
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif

module mem_bus_responder #(
    parameter int          DRAM_AW = 12,
    parameter logic [31:0] IO_BASE = 32'hFFFF_F000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [`IO_BUS_WIDTH_ADDR-1:0] mem_addr,
    input  logic [`IO_BUS_WIDTH_CTRL-1:0] mem_ctrl,
    input  logic [`IO_BUS_WIDTH_DATA-1:0] mem_wd,
    input  logic                          mem_we,
    output logic [`IO_BUS_WIDTH_DATA-1:0] mem_rd,
    input  logic [23:0]                   sw,
    output logic [23:0]                   led,
    output logic                          timer_irq
);

    localparam int RAM_WORDS = 1 << DRAM_AW;

    logic [31:0] r_ram [RAM_WORDS];
    logic [31:0] r_led;
    logic [23:0] r_sw_meta;
    logic [23:0] r_sw_sync;

    logic              w_unsigned;
    logic [1:0]        w_type;
    logic              w_ram_sel;
    logic [DRAM_AW-1:0] w_word_idx;
    logic [31:0]       w_ram_word;
    logic [31:0]       w_io_off;
    logic              w_sel_led;
    logic              w_sel_sw;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ram_rd;
    logic [31:0]       w_rd;
    logic              w_unused;

    assign w_unsigned = mem_ctrl[3];
    assign w_type     = mem_ctrl[2:1];
    assign w_ram_sel  = (mem_addr[31:DRAM_AW+2] == {(30-DRAM_AW){1'b0}});
    assign w_word_idx = mem_addr[DRAM_AW+1:2];
    assign w_ram_word = r_ram[w_word_idx];

    // Peripheral decode by word offset from the window base; RAM takes priority on overlap.
    assign w_io_off  = mem_addr - IO_BASE;
    assign w_sel_led = !w_ram_sel && (w_io_off[31:2] == 30'd0);
    assign w_sel_sw  = !w_ram_sel && (w_io_off[31:2] == 30'd1);

    // The direction bit in mem_ctrl is redundant with mem_we, which is the real strobe.
    assign w_unused = ^{mem_ctrl[0], w_io_off[1:0]};

    // Store lane enables and lane-replicated write data.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_wd;
        case (w_type)
            2'b01: begin
                w_wdata = {2{mem_wd[15:0]}};
                w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                w_wdata = {4{mem_wd[7:0]}};
                w_be    = 4'b0001 << mem_addr[1:0];
            end
            default: begin
                w_wdata = mem_wd;
                w_be    = 4'b1111;
            end
        endcase
    end

    // RAM byte-lane writes; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we && w_ram_sel) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_ram[w_word_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Sub-word extraction and sign/zero extension of RAM loads.
    always_comb begin
        case (mem_addr[1:0])
            2'b00:   w_byte = w_ram_word[7:0];
            2'b01:   w_byte = w_ram_word[15:8];
            2'b10:   w_byte = w_ram_word[23:16];
            2'b11:   w_byte = w_ram_word[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = mem_addr[1] ? w_ram_word[31:16] : w_ram_word[15:0];
        case (w_type)
            2'b01:   w_ram_rd = w_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            2'b10:   w_ram_rd = w_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            default: w_ram_rd = w_ram_word;
        endcase
    end

    // LED register and switch synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_led     <= 32'h0000_0000;
            r_sw_meta <= 24'h00_0000;
            r_sw_sync <= 24'h00_0000;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (mem_we && w_sel_led) begin
                r_led <= mem_wd;
            end
        end
    end

    assign led = r_led[23:0];

`ifdef IO_TIMER_EN
    logic [31:0] r_timer_cnt;
    logic [31:0] r_timer_cmp;
    logic        r_timer_flag;
    logic        w_sel_cnt;
    logic        w_sel_cmp;
    logic        w_sel_stat;

    assign w_sel_cnt  = !w_ram_sel && (w_io_off[31:2] == 30'd2);
    assign w_sel_cmp  = !w_ram_sel && (w_io_off[31:2] == 30'd3);
    assign w_sel_stat = !w_ram_sel && (w_io_off[31:2] == 30'd4);

    // Free-running counter, compare register and sticky match flag (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer_cnt  <= 32'h0000_0000;
            r_timer_cmp  <= 32'h0000_0000;
            r_timer_flag <= 1'b0;
        end else begin
            if (mem_we && w_sel_cnt) begin
                r_timer_cnt <= mem_wd;
            end else begin
                r_timer_cnt <= r_timer_cnt + 32'd1;
            end
            if (mem_we && w_sel_cmp) begin
                r_timer_cmp <= mem_wd;
            end
            if ((r_timer_cmp != 32'h0000_0000) && (r_timer_cnt == r_timer_cmp)) begin
                r_timer_flag <= 1'b1;
            end else if (mem_we && w_sel_stat) begin
                r_timer_flag <= 1'b0;
            end
        end
    end

    assign timer_irq = r_timer_flag;
`else
    assign timer_irq = 1'b0;
`endif

    // Load data mux; peripherals always return the full word.
    always_comb begin
        w_rd = 32'h0000_0000;
        if (w_ram_sel) begin
            w_rd = w_ram_rd;
        end else if (w_sel_led) begin
            w_rd = r_led;
        end else if (w_sel_sw) begin
            w_rd = {8'h00, r_sw_sync};
`ifdef IO_TIMER_EN
        end else if (w_sel_cnt) begin
            w_rd = r_timer_cnt;
        end else if (w_sel_cmp) begin
            w_rd = r_timer_cmp;
        end else if (w_sel_stat) begin
            w_rd = {31'h0000_0000, r_timer_flag};
`endif
        end else begin
            w_rd = 32'h0000_0000;
        end
    end

    assign mem_rd = w_rd;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: vector table for RAM/peripheral accesses
// plus hand sequences for LED, switch sync, timer and reset.
module tb_mem_bus_responder;

    localparam logic [31:0] IO_BASE = 32'hFFFF_F000;

    localparam logic [3:0] C_LW  = 4'b0000;
    localparam logic [3:0] C_SW  = 4'b0001;
    localparam logic [3:0] C_LH  = 4'b0010;
    localparam logic [3:0] C_SH  = 4'b0011;
    localparam logic [3:0] C_LB  = 4'b0100;
    localparam logic [3:0] C_SB  = 4'b0101;
    localparam logic [3:0] C_LW3 = 4'b0110;
    localparam logic [3:0] C_LHU = 4'b1010;
    localparam logic [3:0] C_LBU = 4'b1100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [3:0]  mem_ctrl;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;
    logic [23:0] sw;
    logic [23:0] led;
    logic        timer_irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic        we;
        logic [3:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    mem_bus_responder #(.DRAM_AW(12), .IO_BASE(IO_BASE)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_addr  (mem_addr),
        .mem_ctrl  (mem_ctrl),
        .mem_wd    (mem_wd),
        .mem_we    (mem_we),
        .mem_rd    (mem_rd),
        .sw        (sw),
        .led       (led),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [3:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wd);
        mem_we   = we;
        mem_ctrl = ctrl;
        mem_addr = addr;
        mem_wd   = wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, C_LW, 32'h0000_0000, 32'h0000_0000);
    endtask

    task automatic store(input logic [3:0] ctrl, input logic [31:0] addr, input logic [31:0] wd);
        drive(1'b1, ctrl, addr, wd);
        tick();
        idle();
    endtask

    task automatic load_check(input string name, input logic [3:0] ctrl, input logic [31:0] addr,
                              input logic [31:0] exp);
        drive(1'b0, ctrl, addr, 32'h0000_0000);
        check(name, mem_rd, exp);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 24'h00_0000;
        idle();
        tick();
        tick();
        rst = 1'b0;
        idle();

        check("reset_led", {8'h00, led}, 32'h0000_0000);
        check("reset_irq", {31'h0, timer_irq}, 32'h0000_0000);
        load_check("reset_led_rd", C_LW, IO_BASE, 32'h0000_0000);
        load_check("reset_sw_rd", C_LW, IO_BASE + 32'h4, 32'h0000_0000);

        // {we, ctrl, addr, wd, chk, exp}
        vecs.push_back('{1'b1, C_SW,  32'h0000_0010, 32'h8765_4321, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, C_LB,  32'h0000_0011, 32'h0000_0000, 1'b1, 32'h0000_0043});
        vecs.push_back('{1'b0, C_LB,  32'h0000_0013, 32'h0000_0000, 1'b1, 32'hFFFF_FF87});
        vecs.push_back('{1'b0, C_LBU, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h0000_0087});
        vecs.push_back('{1'b0, C_LH,  32'h0000_0012, 32'h0000_0000, 1'b1, 32'hFFFF_8765});
        vecs.push_back('{1'b0, C_LHU, 32'h0000_0010, 32'h0000_0000, 1'b1, 32'h0000_4321});
        vecs.push_back('{1'b0, C_LW,  32'h0000_0010, 32'h0000_0000, 1'b1, 32'h8765_4321});
        vecs.push_back('{1'b1, C_SB,  32'h0000_0012, 32'h0000_00AA, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, C_LW,  32'h0000_0010, 32'h0000_0000, 1'b1, 32'h87AA_4321});
        vecs.push_back('{1'b1, C_SH,  32'h0000_0010, 32'h0000_BEEF, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, C_LW,  32'h0000_0010, 32'h0000_0000, 1'b1, 32'h87AA_BEEF});
        // read-during-write returns the pre-store word
        vecs.push_back('{1'b1, C_SW,  32'h0000_0010, 32'h1122_3344, 1'b1, 32'h87AA_BEEF});
        vecs.push_back('{1'b0, C_LW,  32'h0000_0010, 32'h0000_0000, 1'b1, 32'h1122_3344});
        vecs.push_back('{1'b0, C_LW3, 32'h0000_0013, 32'h0000_0000, 1'b1, 32'h1122_3344});
        vecs.push_back('{1'b0, C_LW,  32'h8000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000});
        vecs.push_back('{1'b1, C_SW,  32'h0000_0000, 32'h5555_AAAA, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b1, C_SW,  32'h0000_3FFC, 32'hCAFE_F00D, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b1, C_SW,  32'h0000_4000, 32'hDEAD_DEAD, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, C_LW,  32'h0000_3FFC, 32'h0000_0000, 1'b1, 32'hCAFE_F00D});
        vecs.push_back('{1'b0, C_LW,  32'h0000_4000, 32'h0000_0000, 1'b1, 32'h0000_0000});
        vecs.push_back('{1'b0, C_LW,  32'h0000_0000, 32'h0000_0000, 1'b1, 32'h5555_AAAA});
        // peripherals are word-only: byte store writes all of mem_wd, byte load returns full word
        vecs.push_back('{1'b1, C_SB,  IO_BASE,       32'h1234_5678, 1'b0, 32'h0000_0000});
        vecs.push_back('{1'b0, C_LB,  IO_BASE,       32'h0000_0000, 1'b1, 32'h1234_5678});
        vecs.push_back('{1'b0, C_LW,  IO_BASE + 32'h14, 32'h0000_0000, 1'b1, 32'h0000_0000});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wd);
            if (vecs[i].chk) begin
                check($sformatf("vec%0d", i), mem_rd, vecs[i].exp);
            end
            tick();
        end
        idle();

        // LED: visible only after the store edge
        check("led_byte_store", {8'h00, led}, 32'h0034_5678);
        drive(1'b1, C_SW, IO_BASE, 32'h00AB_CDEF);
        check("led_before_edge", {8'h00, led}, 32'h0034_5678);
        tick();
        idle();
        check("led_after_edge", {8'h00, led}, 32'h00AB_CDEF);
        load_check("led_rd", C_LW, IO_BASE, 32'h00AB_CDEF);

        // Switch synchronizer: two edges of latency, stores ignored
        sw = 24'h12_3456;
        load_check("sw_edge0", C_LW, IO_BASE + 32'h4, 32'h0000_0000);
        tick();
        load_check("sw_edge1", C_LW, IO_BASE + 32'h4, 32'h0000_0000);
        tick();
        load_check("sw_edge2", C_LW, IO_BASE + 32'h4, 32'h0012_3456);
        store(C_SW, IO_BASE + 32'h4, 32'hFFFF_FFFF);
        load_check("sw_store_ignored", C_LW, IO_BASE + 32'h4, 32'h0012_3456);

`ifdef IO_TIMER_EN
        // Counter load and wrap
        store(C_SW, IO_BASE + 32'h8, 32'hFFFF_FFFE);
        load_check("cnt_loaded", C_LW, IO_BASE + 32'h8, 32'hFFFF_FFFE);
        tick();
        load_check("cnt_max", C_LW, IO_BASE + 32'h8, 32'hFFFF_FFFF);
        tick();
        load_check("cnt_wrap", C_LW, IO_BASE + 32'h8, 32'h0000_0000);

        // Compare match at count 5
        store(C_SW, IO_BASE + 32'h8, 32'd1000);
        store(C_SW, IO_BASE + 32'hC, 32'd5);
        load_check("cmp_rd", C_LW, IO_BASE + 32'hC, 32'd5);
        store(C_SW, IO_BASE + 32'h8, 32'd0);
        idle();
        check("irq_cnt0", {31'h0, timer_irq}, 32'h0000_0000);
        for (int k = 0; k < 5; k++) tick();
        load_check("cnt_at5", C_LW, IO_BASE + 32'h8, 32'd5);
        check("irq_before_match", {31'h0, timer_irq}, 32'h0000_0000);
        tick();
        check("irq_set", {31'h0, timer_irq}, 32'h0000_0001);
        load_check("stat_rd", C_LW, IO_BASE + 32'h10, 32'h0000_0001);
        store(C_SW, IO_BASE + 32'h10, 32'h0000_0000);
        check("irq_cleared", {31'h0, timer_irq}, 32'h0000_0000);

        // Clear presented in the set cycle: set wins
        store(C_SW, IO_BASE + 32'h8, 32'd3);
        tick();
        tick();
        check("irq_pre_collide", {31'h0, timer_irq}, 32'h0000_0000);
        store(C_SW, IO_BASE + 32'h10, 32'h0000_0000);
        check("irq_set_wins", {31'h0, timer_irq}, 32'h0000_0001);
`else
        load_check("no_timer_cnt", C_LW, IO_BASE + 32'h8, 32'h0000_0000);
        store(C_SW, IO_BASE + 32'hC, 32'h0000_0055);
        load_check("no_timer_cmp", C_LW, IO_BASE + 32'hC, 32'h0000_0000);
        load_check("no_timer_stat", C_LW, IO_BASE + 32'h10, 32'h0000_0000);
        check("no_timer_irq", {31'h0, timer_irq}, 32'h0000_0000);
`endif

        // Mid-run reset with a store presented alongside it
        rst = 1'b1;
        drive(1'b1, C_SW, 32'h0000_0010, 32'hDEAD_BEEF);
        tick();
        rst = 1'b0;
        idle();
        check("rst_led", {8'h00, led}, 32'h0000_0000);
        check("rst_irq", {31'h0, timer_irq}, 32'h0000_0000);
        load_check("rst_ram_kept", C_LW, 32'h0000_0010, 32'h1122_3344);
        load_check("rst_ram_kept2", C_LW, 32'h0000_3FFC, 32'hCAFE_F00D);
        load_check("rst_sw_sync", C_LW, IO_BASE + 32'h4, 32'h0000_0000);
`ifdef IO_TIMER_EN
        load_check("rst_cnt0", C_LW, IO_BASE + 32'h8, 32'h0000_0000);
        load_check("rst_cmp0", C_LW, IO_BASE + 32'hC, 32'h0000_0000);
        tick();
        load_check("rst_cnt1", C_LW, IO_BASE + 32'h8, 32'h0000_0001);
`else
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
